// File: rtl/axi_4_lite_mst_seq_if.sv
// Bundle for the AXI4-Lite master sequencer: local command/response side plus
// the AXI4-Lite master bus toward the register-file slave.
`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif

interface axi_4_lite_mst_seq_if #(
  parameter int ADDR_WIDTH = `C_AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = `C_AXI_DATA_WIDTH
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Handshakes: a transfer happens on a rising edge where VALID && READY; once
  // VALID is raised it and its payload stay put until that edge.
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic                  CMD_WRITE;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [DATA_WIDTH-1:0] CMD_WDATA;
  logic [STRB_WIDTH-1:0] CMD_WSTRB;

  logic                  RSP_VALID;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic [1:0]            RSP_RESP;

  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [2:0]            M_AXI_AWPROT;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [STRB_WIDTH-1:0] M_AXI_WSTRB;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]            M_AXI_ARPROT;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_RESP,
    output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    input  M_AXI_AWREADY,
    output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_WREADY,
    input  M_AXI_BVALID, M_AXI_BRESP,
    output M_AXI_BREADY,
    output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    input  M_AXI_ARREADY,
    input  M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
    output M_AXI_RREADY
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_RESP,
    input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    output M_AXI_AWREADY,
    input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_WREADY,
    output M_AXI_BVALID, M_AXI_BRESP,
    input  M_AXI_BREADY,
    input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    output M_AXI_ARREADY,
    output M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_4_lite_mst_seq.sv
// Single-outstanding AXI4-Lite master: turns one local command into one full
// AXI4-Lite write or read and reports completion with a one-cycle response.
`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif

module axi_4_lite_mst_seq #(
  parameter int         ADDR_WIDTH = `C_AXI_ADDR_WIDTH,
  parameter int         DATA_WIDTH = `C_AXI_DATA_WIDTH,
  parameter logic [2:0] PROT_VALUE = 3'b000
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  axi_4_lite_mst_seq_if.master bus,
  output logic [2:0]          state_dbg
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t                state;
  logic                  cmd_ready;
  logic                  awvalid;
  logic                  wvalid;
  logic                  bready;
  logic                  arvalid;
  logic                  rready;
  logic                  aw_done;
  logic                  w_done;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid && bus.M_AXI_AWREADY;
  assign w_hs  = wvalid && bus.M_AXI_WREADY;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.CMD_VALID && cmd_ready) begin
            addr_q    <= bus.CMD_ADDR;
            wdata_q   <= bus.CMD_WDATA;
            wstrb_q   <= bus.CMD_WSTRB;
            cmd_ready <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (bus.CMD_WRITE) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WRITE;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end
        WRITE: begin
          // AW and W complete independently, in either order or together.
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.M_AXI_BVALID && bready) begin
            bready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= bus.M_AXI_BRESP;
            rsp_rdata <= '0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        RD_ADDR: begin
          if (arvalid && bus.M_AXI_ARREADY) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.M_AXI_RVALID && rready) begin
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= bus.M_AXI_RDATA;
            rsp_resp  <= bus.M_AXI_RRESP;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.CMD_READY     = cmd_ready;
  assign bus.RSP_VALID     = rsp_valid;
  assign bus.RSP_RDATA     = rsp_rdata;
  assign bus.RSP_RESP      = rsp_resp;
  assign bus.M_AXI_AWVALID = awvalid;
  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_AWPROT  = PROT_VALUE;
  assign bus.M_AXI_WVALID  = wvalid;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = wstrb_q;
  assign bus.M_AXI_BREADY  = bready;
  assign bus.M_AXI_ARVALID = arvalid;
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_ARPROT  = PROT_VALUE;
  assign bus.M_AXI_RREADY  = rready;
  assign state_dbg         = state;
endmodule

// File: tb/tb_axi_4_lite_mst_seq.sv
// Bench for axi_4_lite_mst_seq: directed commands into a configurable
// register-file slave model, with a response scoreboard.
module tb_axi_4_lite_mst_seq;
  localparam int AW = 32;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] state_dbg;

  axi_4_lite_mst_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_4_lite_mst_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT_VALUE(3'b000)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (bus),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- slave model ----------------
  int         aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  bit         w_after_aw = 0;
  logic [1:0] b_resp_cfg = 2'b00;
  logic [31:0] regs [4];
  int aw_fires = 0, w_fires = 0;

  bit aw_got, w_got, b_pend, r_pend;
  bit aw_fire, w_fire, b_fire, ar_fire, r_fire;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic        p_awvalid, p_wvalid, p_arvalid, p_bready, p_rready;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
      bus.M_AXI_BRESP = 0; bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0;
      bus.M_AXI_RDATA = 0; bus.M_AXI_RRESP = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_bready = 0; p_rready = 0;
    end else begin
      aw_fire = p_awvalid && bus.M_AXI_AWREADY;
      w_fire  = p_wvalid && bus.M_AXI_WREADY;
      b_fire  = bus.M_AXI_BVALID && p_bready;
      ar_fire = p_arvalid && bus.M_AXI_ARREADY;
      r_fire  = bus.M_AXI_RVALID && p_rready;

      // a pending VALID must hold with a stable payload; an accepted one must drop
      if (p_awvalid && !aw_fire) begin
        chk("awvalid_held", 64'(bus.M_AXI_AWVALID), 64'(1));
        chk("awaddr_stable", 64'(bus.M_AXI_AWADDR), 64'(p_awaddr));
      end
      if (p_wvalid && !w_fire) begin
        chk("wvalid_held", 64'(bus.M_AXI_WVALID), 64'(1));
        chk("wdata_stable", 64'({bus.M_AXI_WSTRB, bus.M_AXI_WDATA}), 64'({p_wstrb, p_wdata}));
      end
      if (p_arvalid && !ar_fire) begin
        chk("arvalid_held", 64'(bus.M_AXI_ARVALID), 64'(1));
        chk("araddr_stable", 64'(bus.M_AXI_ARADDR), 64'(p_araddr));
      end
      if (aw_fire) chk("awvalid_drop", 64'(bus.M_AXI_AWVALID), 64'(0));
      if (w_fire)  chk("wvalid_drop", 64'(bus.M_AXI_WVALID), 64'(0));

      if (aw_fire) begin aw_fires++; aw_got = 1; s_awaddr = p_awaddr; end
      if (w_fire) begin w_fires++; w_got = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; end
      if (aw_got && w_got) begin
        for (int i = 0; i < 4; i++)
          if (s_wstrb[i]) regs[s_awaddr[3:2]][i*8 +: 8] = s_wdata[i*8 +: 8];
        aw_got = 0; w_got = 0; b_pend = 1; b_cnt = b_lat;
      end
      if (b_fire) bus.M_AXI_BVALID = 0;
      if (b_pend) begin
        if (b_cnt == 0) begin
          bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = b_resp_cfg; b_pend = 0;
        end else b_cnt--;
      end

      if (ar_fire) begin r_pend = 1; r_cnt = r_lat; s_araddr = p_araddr; end
      if (r_fire) bus.M_AXI_RVALID = 0;
      if (r_pend) begin
        if (r_cnt == 0) begin
          bus.M_AXI_RVALID = 1; bus.M_AXI_RDATA = regs[s_araddr[3:2]];
          bus.M_AXI_RRESP = 2'b00; r_pend = 0;
        end else r_cnt--;
      end

      if (bus.M_AXI_AWVALID) begin
        if (aw_cnt >= aw_lat) bus.M_AXI_AWREADY = 1;
        else begin bus.M_AXI_AWREADY = 0; aw_cnt++; end
      end else begin bus.M_AXI_AWREADY = 0; aw_cnt = 0; end

      if (bus.M_AXI_WVALID && (!w_after_aw || aw_got)) begin
        if (w_cnt >= w_lat) bus.M_AXI_WREADY = 1;
        else begin bus.M_AXI_WREADY = 0; w_cnt++; end
      end else begin bus.M_AXI_WREADY = 0; w_cnt = 0; end

      if (bus.M_AXI_ARVALID) begin
        if (ar_cnt >= ar_lat) bus.M_AXI_ARREADY = 1;
        else begin bus.M_AXI_ARREADY = 0; ar_cnt++; end
      end else begin bus.M_AXI_ARREADY = 0; ar_cnt = 0; end

      p_awvalid = bus.M_AXI_AWVALID; p_awaddr = bus.M_AXI_AWADDR;
      p_wvalid = bus.M_AXI_WVALID; p_wdata = bus.M_AXI_WDATA; p_wstrb = bus.M_AXI_WSTRB;
      p_arvalid = bus.M_AXI_ARVALID; p_araddr = bus.M_AXI_ARADDR;
      p_bready = bus.M_AXI_BREADY; p_rready = bus.M_AXI_RREADY;
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [33:0] exp_q [$];
  logic [33:0] mon_e;
  int   rsp_seen = 0;
  int   rsp_cyc = 0;
  logic prev_rsp = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) prev_rsp = 1'b0;
    else begin
      if (bus.RSP_VALID) begin
        chk("rsp_single_cycle", 64'(prev_rsp), 64'(0));
        chk("rsp_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("rsp_resp_rdata", 64'({bus.RSP_RESP, bus.RSP_RDATA}), 64'(mon_e));
        end
        rsp_seen++;
        rsp_cyc = cyc;
      end
      prev_rsp = bus.RSP_VALID;
    end
  end

  // ---------------- driver tasks ----------------
  int acc_cyc = 0;

  task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [33:0] exp);
    bit   acc;
    logic rdy;
    @(negedge clk);
    bus.CMD_VALID = 1; bus.CMD_WRITE = wr; bus.CMD_ADDR = addr;
    bus.CMD_WDATA = data; bus.CMD_WSTRB = strb;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      rdy = bus.CMD_READY;
      acc_cyc = cyc;
      @(posedge clk);
      if (rdy) acc = 1;
      else @(negedge clk);
    end
    chk("cmd_accepted", 64'(acc), 64'(1));
    chk("one_outstanding", 64'(exp_q.size()), 64'(0));
    exp_q.push_back(exp);
  endtask

  task automatic release_cmd();
    @(negedge clk);
    bus.CMD_VALID = 0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_seen < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrived", 64'(rsp_seen >= target), 64'(1));
  endtask

  task automatic chk_latency(input string name);
    chk(name, 64'((rsp_cyc - acc_cyc - 1) <= 4), 64'(1));
  endtask

  // ---------------- directed sequence ----------------
  int base_aw, base_w, base_seen;

  initial begin
    for (int i = 0; i < 4; i++) regs[i] = 32'h0;
    bus.CMD_VALID = 0; bus.CMD_WRITE = 0; bus.CMD_ADDR = 0;
    bus.CMD_WDATA = 0; bus.CMD_WSTRB = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 64'(bus.CMD_READY), 64'(1));
    chk("rst_valids", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}), 64'(0));
    chk("rst_readies", 64'({bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 64'(0));
    chk("rst_rsp", 64'({bus.RSP_VALID, bus.RSP_RESP, bus.RSP_RDATA}), 64'(0));
    chk("rst_regs", 64'({bus.M_AXI_AWADDR, bus.M_AXI_WDATA}), 64'(0));
    chk("rst_prot", 64'({bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}), 64'(0));
    chk("rst_state", 64'(state_dbg), 64'(0));
    @(negedge clk);
    #2 rst_n = 1;

    // write with WREADY only after AW acceptance
    w_after_aw = 1;
    base_aw = aw_fires; base_w = w_fires;
    send(1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, {2'b00, 32'h0});
    release_cmd();
    wait_rsp(1);
    chk_latency("wr_latency");
    chk("aw_handshakes", 64'(aw_fires - base_aw), 64'(1));
    chk("w_handshakes", 64'(w_fires - base_w), 64'(1));
    chk("slave_reg1", 64'(regs[1]), 64'(32'hDEAD_BEEF));
    w_after_aw = 0;

    send(0, 32'h0000_0004, 32'h0, 4'h0, {2'b00, 32'hDEAD_BEEF});
    release_cmd();
    wait_rsp(2);
    chk_latency("rd_latency");

    send(1, 32'h0000_0004, 32'h1122_3344, 4'b0101, {2'b00, 32'h0});
    release_cmd();
    wait_rsp(3);
    send(0, 32'h0000_0004, 32'h0, 4'h0, {2'b00, 32'hDE22_BE44});
    release_cmd();
    wait_rsp(4);

    // W accepted well before AW, slow SLVERR response
    aw_lat = 3; w_lat = 0; b_lat = 5; b_resp_cfg = 2'b10;
    send(1, 32'h0000_0008, 32'hCAFE_F00D, 4'hF, {2'b10, 32'h0});
    release_cmd();
    wait_rsp(5);
    aw_lat = 0; b_lat = 0; b_resp_cfg = 2'b00;

    // CMD_VALID held across four mixed commands
    send(1, 32'h0000_0000, 32'h0102_0304, 4'hF, {2'b00, 32'h0});
    send(0, 32'h0000_0000, 32'h0, 4'h0, {2'b00, 32'h0102_0304});
    send(1, 32'h0000_000C, 32'hA5A5_A5A5, 4'b1100, {2'b00, 32'h0});
    send(0, 32'h0000_000C, 32'h0, 4'h0, {2'b00, 32'hA5A5_0000});
    release_cmd();
    wait_rsp(9);

    // reset while waiting in RD_DATA
    r_lat = 20;
    send(0, 32'h0000_0004, 32'h0, 4'h0, {2'b00, 32'hDE22_BE44});
    release_cmd();
    for (int i = 0; i < 50 && !bus.M_AXI_RREADY; i++) @(negedge clk);
    chk("reached_rd_data", 64'(bus.M_AXI_RREADY), 64'(1));
    base_seen = rsp_seen;
    #2 rst_n = 0;
    #1;
    chk("abort_valids", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}), 64'(0));
    chk("abort_readies", 64'({bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 64'(0));
    chk("abort_rsp_valid", 64'(bus.RSP_VALID), 64'(0));
    exp_q.delete();
    r_lat = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    repeat (10) @(negedge clk);
    chk("no_rsp_after_abort", 64'(rsp_seen), 64'(base_seen));
    chk("cmd_ready_after_reset", 64'(bus.CMD_READY), 64'(1));

    send(0, 32'h0000_0004, 32'h0, 4'h0, {2'b00, 32'hDE22_BE44});
    release_cmd();
    wait_rsp(base_seen + 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/axi_4_lite_mst_seq.md
Name: axi_4_lite_mst_seq

Overview:
- Single-outstanding AXI4-Lite master sequencer.
- Converts a simple command/response interface into complete AXI4-Lite write or read transactions toward the register-file slave (axi_4_lite_slv).
- Sits between local control logic (test sequencer, CPU-less config engine) and the slave.
- Tolerates any AW/W acceptance order and any slave ready/valid latency.

Parameters:
ADDR_WIDTH, `C_AXI_ADDR_WIDTH, address width of CMD_ADDR and M_AXI_AWADDR/ARADDR
DATA_WIDTH, `C_AXI_DATA_WIDTH, data width; strobe width is DATA_WIDTH/8
PROT_VALUE, 3'b000, constant driven on M_AXI_AWPROT and M_AXI_ARPROT

Ports:
S_AXI_ACLK  in  1  clock; all logic on rising edge
S_AXI_ARESETN  in  1  asynchronous active-low reset
CMD_VALID  in  1  command valid
CMD_READY  out  1  command accepted when CMD_VALID&&CMD_READY
CMD_WRITE  in  1  1=write, 0=read
CMD_ADDR  in  ADDR_WIDTH  byte address
CMD_WDATA  in  DATA_WIDTH  write data
CMD_WSTRB  in  DATA_WIDTH/8  write byte strobes
RSP_VALID  out  1  one-cycle pulse; transaction complete
RSP_RDATA  out  DATA_WIDTH  read data; 0 after writes
RSP_RESP  out  2  BRESP or RRESP of completed transaction
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_AWADDR  out  ADDR_WIDTH  write address
M_AXI_AWPROT  out  3  PROT_VALUE
M_AXI_WVALID  out  1  write data valid
M_AXI_WREADY  in  1  write data ready
M_AXI_WDATA  out  DATA_WIDTH  write data
M_AXI_WSTRB  out  DATA_WIDTH/8  write strobes
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready
M_AXI_BRESP  in  2  write response
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_ARADDR  out  ADDR_WIDTH  read address
M_AXI_ARPROT  out  3  PROT_VALUE
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready
M_AXI_RDATA  in  DATA_WIDTH  read data
M_AXI_RRESP  in  2  read response

Behaviour:
- Reset (S_AXI_ARESETN low, asynchronous):
  - state=IDLE, CMD_READY=1.
  - All M_AXI VALID/READY outputs 0, RSP_VALID=0, RSP_RDATA=0, RSP_RESP=2'b00.
  - Address/data/strobe registers 0.
- FSM states: IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID: latch ADDR/WDATA/WSTRB; CMD_READY=0 next cycle.
  - Write command: next state WRITE, AWVALID=1 and WVALID=1 both asserted the cycle after acceptance.
  - Read command: next state RD_ADDR, ARVALID=1.
- WRITE:
  - Independent aw_done/w_done flags.
  - AWVALID drops the cycle after AW handshake; WVALID drops the cycle after W handshake.
  - Simultaneous AW and W handshakes in one cycle are legal and set both flags.
  - Addr/data/strobe stay stable while VALID is high; VALID never deasserts before its handshake.
  - When both flags are set: BREADY=1, go to WR_RESP.
  - A slave that raises WREADY only after AW acceptance must complete correctly.
- WR_RESP:
  - On BVALID&&BREADY: BREADY=0, RSP_VALID=1 for exactly one cycle, RSP_RESP=BRESP, RSP_RDATA=0, return to IDLE with CMD_READY=1.
- RD_ADDR:
  - On ARVALID&&ARREADY: ARVALID=0, RREADY=1, go to RD_DATA.
- RD_DATA:
  - On RVALID&&RREADY: capture RDATA/RRESP, RREADY=0, RSP_VALID pulse, return to IDLE.
- RSP_RDATA/RSP_RESP hold their last value until the next completion.
- Latency against a zero-wait slave:
  - Write: cmd accept → RSP_VALID, at most 4 cycles.
  - Read: cmd accept → RSP_VALID, at most 4 cycles.
- Exactly one transaction outstanding; commands are never dropped. CMD_VALID while CMD_READY=0 is simply stalled.
- Non-OKAY responses (SLVERR/DECERR) are passed through to RSP_RESP unchanged; no retry.
- Reset mid-transaction:
  - Immediate return to IDLE and all VALID/READY outputs low.
  - No RSP_VALID is issued for the aborted transaction.

Test Plan:
- Write 0x0000_0004, data 0xDEADBEEF, strb 4'hF, slave with AWREADY=1 and WREADY after AW → single AW and single W handshake, RSP_VALID pulse with RSP_RESP=2'b00, then slave reg1=0xDEADBEEF.
- Read 0x4 after previous write → RSP_RDATA=0xDEADBEEF, RSP_RESP=0, RSP_VALID high exactly 1 cycle.
- Write data 0x11223344, strb 4'b0101, to a reg holding 0xDEADBEEF → readback 0xDE22BE44.
- Stub slave: WREADY asserted 3 cycles before AWREADY; BVALID delayed 5 cycles; BRESP=SLVERR → AWADDR/WDATA stable while VALID high; RSP_RESP=2'b10.
- Back-to-back CMD_VALID held high for 4 mixed commands → each accepted only in IDLE; 4 RSP_VALID pulses in order with no overlap.
- Assert S_AXI_ARESETN low while in RD_DATA → all M_AXI VALID/READY 0 immediately; no RSP_VALID; CMD_READY=1 after release.
